vga_axis_timing: RTL and testbench
==================================

Name: vga_axis_timing

Overview:
- Parametrised single-axis VGA timing generator: counter plus region state machine (ACTIVE, FRONT, SYNC, BACK).
- Replaces fixed-length line and frame counters.
- One instance per axis.
  - Horizontal instance: enable tied high.
  - Vertical instance: enable driven by the horizontal instance's tc.
- Outputs sync, display-enable, terminal-count and frame-start strobes for the pixel pipeline and the colour mux.

Parameters:
- ACTIVE, 480, visible count per line/frame
- FRONT, 10, front porch length
- SYNC, 2, sync pulse length
- BACK, 33, back porch length
- CNT_W, 16, counter width
- SYNC_POL, 0, asserted level of sync_out (0 = active-low, per 640x480@60)

Ports:
- clk_25  in  1  25 MHz pixel clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  advance counter one step this cycle
- clear  in  1  synchronous restart to count 0 / ACTIVE; priority over enable
- count  out  CNT_W  current position, 0..TOTAL-1
- region  out  2  current region: 0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK
- active_out  out  1  high while region==ACTIVE
- sync_out  out  1  SYNC_POL while region==SYNC, else ~SYNC_POL
- tc  out  1  combinational terminal-count strobe for chaining
- frame_start  out  1  one-cycle registered pulse when count wraps to 0

Behaviour:
- TOTAL = ACTIVE+FRONT+SYNC+BACK.
- Elaboration error if any parameter is < 1 or TOTAL > 2**CNT_W.
- Reset (async assert, released synchronously to clk_25 by the top-level):
  - count=0, region=ACTIVE, active_out=1, sync_out=~SYNC_POL, frame_start=0.
- All outputs except tc are registered. region, active_out and sync_out always correspond to the same-cycle count, with no one-cycle skew.
- enable=1, clear=0:
  - count < TOTAL-1: count <= count+1.
  - count == TOTAL-1: count <= 0 and frame_start <= 1 next cycle.
- enable=0, clear=0: count, region, active_out and sync_out hold; frame_start <= 0.
- clear=1, any enable: count<=0, region<=ACTIVE, active_out<=1, sync_out<=~SYNC_POL, frame_start<=0. No wrap is reported.
- Region FSM advances only on enabled increments:
  - ACTIVE -> FRONT when count goes ACTIVE-1 -> ACTIVE.
  - FRONT -> SYNC at ACTIVE+FRONT.
  - SYNC -> BACK at ACTIVE+FRONT+SYNC.
  - BACK -> ACTIVE on wrap to 0.
  - Next region is decoded from the next count value, so the FSM never skips or stalls.
- Single-length regions (e.g. FRONT=1): the region lasts exactly one enabled step.
- tc = enable & ~clear & (count == TOTAL-1). Never registered, so a chained instance steps on the same edge as the wrap.
- Compare arithmetic is done in CNT_W bits. TOTAL-1 is precomputed as a localparam, with no overflow at TOTAL = 2**CNT_W.
- Reset asserted mid-line forces reset values immediately, independent of clk_25. Counting resumes from 0 on the first enabled edge after release.

Decomposition:
- Shared package vga_timing_pkg holds:
  - region encodings REG_ACTIVE/REG_FRONT/REG_SYNC/REG_BACK (2-bit)
  - 640x480@60 constants: H 640/16/96/48; V 480/10/2/33; both SYNC_POL 0
- No sub-module inside this block.
- Companion wrapper vga_sync_gen instantiates two vga_axis_timing (H then V, chained via tc) and is specified separately.

Test Plan:
- Reset then enable=1 for 525 cycles (default params):
  - count steps 0..524 then 0.
  - frame_start high exactly one cycle after the 524->0 step.
  - tc high only while count==524.
- Region boundaries (default params), with the listed values present on the same cycle:
  - count 479: ACTIVE, active_out=1.
  - count 480: FRONT, active_out=0.
  - count 490: SYNC, sync_out=0.
  - count 492: BACK, sync_out=1.
  - count 0: ACTIVE.
- Enable gating: toggle enable 1/0 pseudo-randomly for 2000 cycles.
  - count advances only on enable=1 cycles.
  - tc never asserts while enable=0.
  - Reference-model compare every cycle.
- Clear priority: at count=300, assert clear with enable=1 for one cycle.
  - Next cycle count=0, region=ACTIVE, frame_start=0.
  - Same at count=524: tc=0 that cycle.
- Async reset mid-operation: assert reset_n low between edges at count=491 (SYNC).
  - Outputs go to reset values before the next clk_25 edge.
  - Restart from 0 after release.
- H/V chain via vga_sync_gen at 800x525:
  - Vertical count increments once per 800 pixels.
  - Vertical frame_start every 420000 clocks.
  - Hsync low 96 clocks per line; vsync low 1600 clocks per frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing blocks: region encodings and
// 640x480@60 timing constants for the horizontal and vertical axes.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FRONT  = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BACK   = 2'd3
    } region_t;

    localparam int H_ACTIVE   = 640;
    localparam int H_FRONT    = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BACK     = 48;
    localparam bit H_SYNC_POL = 1'b0;

    localparam int V_ACTIVE   = 480;
    localparam int V_FRONT    = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 33;
    localparam bit V_SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_axis_timing.sv
// Single-axis VGA timing generator: position counter plus region FSM with
// registered sync/display-enable outputs and a combinational terminal count.
module vga_axis_timing
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = 480,
    parameter int FRONT    = 10,
    parameter int SYNC     = 2,
    parameter int BACK     = 33,
    parameter int CNT_W    = 16,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk_25,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       region,
    output logic             active_out,
    output logic             sync_out,
    output logic             tc,
    output logic             frame_start
);

    localparam longint TOTAL   = longint'(ACTIVE) + FRONT + SYNC + BACK;
    localparam longint CNT_MAX = longint'(1) << CNT_W;

    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1 || CNT_W < 1 || TOTAL > CNT_MAX) begin : g_bad_params
        $error("vga_axis_timing: region lengths must be >= 1 and TOTAL must fit in CNT_W bits");
    end

    // Boundaries are all below TOTAL, so they fit in CNT_W bits even at TOTAL == 2**CNT_W
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] B_FRONT = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] B_SYNC  = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] B_BACK  = CNT_W'(ACTIVE + FRONT + SYNC);

    logic [CNT_W-1:0] count_reg, count_next;
    region_t          state_reg, state_next;
    logic             active_reg, active_next;
    logic             sync_reg, sync_next;
    logic             fs_reg, fs_next;

    assign tc = enable & ~clear & (count_reg == LAST);

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            count_reg  <= '0;
            state_reg  <= REG_ACTIVE;
            active_reg <= 1'b1;
            sync_reg   <= ~SYNC_POL;
            fs_reg     <= 1'b0;
        end else begin
            count_reg  <= count_next;
            state_reg  <= state_next;
            active_reg <= active_next;
            sync_reg   <= sync_next;
            fs_reg     <= fs_next;
        end
    end

    // Transitions look at the next count so the registered region lines up
    // with the registered count on the same cycle.
    always_comb begin
        count_next = count_reg;
        state_next = state_reg;
        fs_next    = 1'b0;
        if (clear) begin
            count_next = '0;
            state_next = REG_ACTIVE;
        end else if (enable) begin
            if (count_reg == LAST) begin
                count_next = '0;
                fs_next    = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
            case (state_reg)
                REG_ACTIVE: if (count_next == B_FRONT) state_next = REG_FRONT;
                REG_FRONT:  if (count_next == B_SYNC)  state_next = REG_SYNC;
                REG_SYNC:   if (count_next == B_BACK)  state_next = REG_BACK;
                REG_BACK:   if (count_next == '0)      state_next = REG_ACTIVE;
                default:    state_next = REG_ACTIVE;
            endcase
        end
        active_next = (state_next == REG_ACTIVE);
        sync_next   = (state_next == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    assign count       = count_reg;
    assign region      = state_reg;
    assign active_out  = active_reg;
    assign sync_out    = sync_reg;
    assign frame_start = fs_reg;

endmodule

// File: tb/tb_vga_axis_timing.sv
// Randomised self-checking bench for vga_axis_timing at default (480/10/2/33)
// parameters, compared against an arithmetic position/region model.
module tb_vga_axis_timing;

    localparam int ACTIVE = 480;
    localparam int FRONT  = 10;
    localparam int SYNC   = 2;
    localparam int BACK   = 33;
    localparam int TOTAL  = ACTIVE + FRONT + SYNC + BACK;
    localparam int LAST   = TOTAL - 1;

    logic        clk_25 = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] count;
    logic [1:0]  region;
    logic        active_out;
    logic        sync_out;
    logic        tc;
    logic        frame_start;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_cnt = 0;
    int m_fs  = 0;

    always #20 clk_25 = ~clk_25;

    vga_axis_timing dut (
        .clk_25      (clk_25),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear       (clear),
        .count       (count),
        .region      (region),
        .active_out  (active_out),
        .sync_out    (sync_out),
        .tc          (tc),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (model count %0d)", tag, got, exp, m_cnt);
        end
    endtask

    function automatic int exp_region(input int c);
        if (c < ACTIVE) return 0;
        if (c < ACTIVE + FRONT) return 1;
        if (c < ACTIVE + FRONT + SYNC) return 2;
        return 3;
    endfunction

    task automatic check_regs();
        check("count", int'(count), m_cnt);
        check("region", int'(region), exp_region(m_cnt));
        check("active_out", int'(active_out), (exp_region(m_cnt) == 0) ? 1 : 0);
        check("sync_out", int'(sync_out), (exp_region(m_cnt) == 2) ? 0 : 1);
        check("frame_start", int'(frame_start), m_fs);
    endtask

    // Called at a negedge: drive inputs, check tc, clock once, check registers.
    task automatic step(input logic en, input logic clr);
        enable = en;
        clear  = clr;
        #1;
        check("tc", int'(tc), (en && !clr && m_cnt == LAST) ? 1 : 0);
        @(posedge clk_25);
        m_fs = 0;
        if (clr) m_cnt = 0;
        else if (en) begin
            if (m_cnt == LAST) begin
                m_cnt = 0;
                m_fs  = 1;
            end else m_cnt = m_cnt + 1;
        end
        @(negedge clk_25);
        check_regs();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * TOTAL && m_cnt != target; i++) step(1'b1, 1'b0);
        check("run_to", m_cnt, target);
    endtask

    initial begin
        // reset state
        #30;
        check_regs();
        @(negedge clk_25);
        reset_n = 1'b1;

        // one full line plus the wrap
        for (int i = 0; i < TOTAL + 1; i++) step(1'b1, 1'b0);

        // random enable gating with occasional clear
        for (int i = 0; i < 2000; i++)
            step(1'(($urandom % 2)), 1'(($urandom % 64) == 0));

        // clear priority mid-line and at terminal count
        run_to(300);
        step(1'b1, 1'b1);
        check("clear_at_300", int'(count), 0);
        run_to(LAST);
        step(1'b1, 1'b1);
        check("clear_at_last_fs", int'(frame_start), 0);
        step(1'b1, 1'b0);

        // asynchronous reset while in SYNC, between clock edges
        run_to(491);
        #5;
        reset_n = 1'b0;
        #1;
        m_cnt = 0;
        m_fs  = 0;
        check_regs();
        @(negedge clk_25);
        check_regs();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
